// File: rtl/aes_block_tx.sv
// aes_block_tx: serialises one NUM_BYTES block, most significant byte first, into a byte-wide UART transmitter.
// Latency: first tx_start_o in the cycle after accept; each later byte (or block_done_o) one cycle after tx_done_tick_i.
// Backpressure: block_ready_o is high only in IDLE; a new block waits until the previous one has fully drained.
module aes_block_tx #(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [8*NUM_BYTES-1:0] block_i,
  input  logic                   block_valid_i,
  output logic                   block_ready_o,
  output logic [7:0]             tx_din_o,
  output logic                   tx_start_o,
  input  logic                   tx_done_tick_i,
  output logic                   busy_o,
  output logic                   block_done_o
);

  localparam int BW = 8 * NUM_BYTES;
  // Keep the counter at least one bit wide so a single-byte build still elaborates.
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] shift_q, shift_d;

  // Next-state, byte counter and shift register update; ticks outside WAIT are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (block_valid_i) begin
          shift_d = block_i;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done_tick_i) begin
          if (cnt_q == LAST_IDX) begin
            // Last byte: leave the shift register alone so tx_din_o holds through DONE.
            state_d = DONE;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + CW'(1);
            state_d = START;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any block in flight and clears the outgoing byte.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign block_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign tx_start_o    = (state_q == START);
  assign block_done_o  = (state_q == DONE);
  assign tx_din_o      = shift_q[BW-1 -: 8];

endmodule

// File: tb/tb_aes_block_tx.sv
// tb_aes_block_tx: drives aes_block_tx against a 20-cycle UART transmitter model and checks bytes and timing.
// Latency: every check is made #1 after a rising edge or from logs taken on the falling edge.
// Backpressure: blocks are offered only while block_ready_o is high, except the deliberate busy-time pulse.
module tb_aes_block_tx;

  localparam int NB = 16;

  logic            clk;
  logic            rst_ni;
  logic [8*NB-1:0] block_i;
  logic            block_valid_i;
  logic            block_ready_o;
  logic [7:0]      tx_din_o;
  logic            tx_start_o;
  logic            busy_o;
  logic            block_done_o;
  logic            uart_tick;
  logic            stray_tick;

  int uart_delay;
  int uart_cd;
  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int din_unstable = 0;
  logic [7:0] last_din = 8'h00;

  logic [7:0] strobe_bytes[$];
  int start_e[$];
  int tick_e[$];
  int done_e[$];
  int acc_e[$];

  aes_block_tx #(.NUM_BYTES(NB)) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .block_i        (block_i),
    .block_valid_i  (block_valid_i),
    .block_ready_o  (block_ready_o),
    .tx_din_o       (tx_din_o),
    .tx_start_o     (tx_start_o),
    .tx_done_tick_i (uart_tick | stray_tick),
    .busy_o         (busy_o),
    .block_done_o   (block_done_o)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to timestamp events.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  // UART transmitter model: one-cycle done tick uart_delay cycles after each start strobe.
  initial begin
    uart_tick = 1'b0;
    uart_cd   = 0;
    forever begin
      @(posedge clk);
      #2;
      uart_tick = 1'b0;
      if (!rst_ni) begin
        uart_cd = 0;
      end else begin
        if (uart_cd > 0) begin
          uart_cd--;
          if (uart_cd == 0) uart_tick = 1'b1;
        end
        if (tx_start_o) uart_cd = uart_delay;
      end
    end
  end

  // Falling-edge monitor: logs accepts, strobes, ticks seen in WAIT, done pulses and byte stability.
  initial begin
    forever begin
      @(negedge clk);
      if (block_valid_i && block_ready_o && rst_ni) acc_e.push_back(edge_cnt + 1);
      if (tx_start_o) begin
        strobe_bytes.push_back(tx_din_o);
        start_e.push_back(edge_cnt);
        last_din = tx_din_o;
      end else if (busy_o && !block_done_o && tx_din_o !== last_din) begin
        din_unstable++;
      end
      if ((uart_tick | stray_tick) && busy_o && !tx_start_o && !block_done_o) tick_e.push_back(edge_cnt + 1);
      if (block_done_o) done_e.push_back(edge_cnt);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    strobe_bytes.delete();
    start_e.delete();
    tick_e.delete();
    done_e.delete();
    acc_e.delete();
    din_unstable = 0;
  endtask

  // Reference: byte i of a block is the i-th most significant byte.
  function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] b, input int i);
    logic [8*NB-1:0] t;
    t = b >> (8 * (NB - 1 - i));
    return t[7:0];
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_block(input string tag, input logic [8*NB-1:0] blk, input int base);
    for (int i = 0; i < NB; i++) begin
      logic [7:0] o;
      o = (base + i < strobe_bytes.size()) ? strobe_bytes[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {120'd0, o}, {120'd0, exp_byte(blk, i)});
    end
  endtask

  // Offer one block for a single cycle; returns #1 after the accepting edge.
  task automatic send(input logic [8*NB-1:0] blk);
    int n;
    n = 0;
    while (!block_ready_o && n < 50) begin
      step(1);
      n++;
    end
    block_i       = blk;
    block_valid_i = 1'b1;
    step(1);
    block_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!block_done_o && n < 800) begin
      step(1);
      n++;
    end
    chk({tag, "_done_seen"}, {127'd0, block_done_o}, 128'd1);
  endtask

  initial begin
    logic [8*NB-1:0] blk;
    int n;
    int bad;
    int ns;

    rst_ni        = 1'b0;
    block_i       = '0;
    block_valid_i = 1'b0;
    stray_tick    = 1'b0;
    uart_delay    = 20;

    // Reset state.
    step(3);
    chk("rst_ready", {127'd0, block_ready_o}, 128'd1);
    chk("rst_busy",  {127'd0, busy_o},        128'd0);
    chk("rst_start", {127'd0, tx_start_o},    128'd0);
    chk("rst_done",  {127'd0, block_done_o},  128'd0);
    chk("rst_din",   {120'd0, tx_din_o},      128'd0);
    rst_ni = 1'b1;
    step(2);

    // Basic block, latency and per-byte timing.
    clear_log();
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    send(blk);
    chk("lat_start", {127'd0, tx_start_o},    128'd1);
    chk("lat_din",   {120'd0, tx_din_o},      128'h00);
    chk("lat_ready", {127'd0, block_ready_o}, 128'd0);
    chk("lat_busy",  {127'd0, busy_o},        128'd1);
    step(1);
    chk("lat_start_once", {127'd0, tx_start_o}, 128'd0);
    wait_done("t1");
    chk("t1_ready_in_done", {127'd0, block_ready_o}, 128'd0);
    step(1);
    chk("t1_ready_after", {127'd0, block_ready_o}, 128'd1);
    chk("t1_strobes", strobe_bytes.size(), NB);
    check_block("t1", blk, 0);
    chk("t1_dones", done_e.size(), 1);
    chk("t1_acc_to_start", qat(start_e, 0), qat(acc_e, 0));
    chk("t1_din_stable", din_unstable, 0);
    bad = 0;
    if (start_e.size() < NB || tick_e.size() < NB) bad = 99;
    else for (int i = 1; i < NB; i++) if (start_e[i] != tick_e[i-1]) bad++;
    chk("t1_tick_to_start", bad, 0);
    chk("t1_tick_to_done", qat(done_e, 0), qat(tick_e, NB - 1));

    // Back-to-back with valid held high.
    clear_log();
    block_i       = {16{8'hA5}};
    block_valid_i = 1'b1;
    n = 0;
    while (acc_e.size() < 1 && n < 10) begin step(1); n++; end
    block_i = {16{8'h3C}};
    while (acc_e.size() < 2 && n < 1000) begin step(1); n++; end
    block_valid_i = 1'b0;
    chk("t2_accepts", acc_e.size(), 2);
    wait_done("t2");
    step(1);
    chk("t2_strobes", strobe_bytes.size(), 2 * NB);
    check_block("t2a", {16{8'hA5}}, 0);
    check_block("t2b", {16{8'h3C}}, NB);
    chk("t2_dones", done_e.size(), 2);
    chk("t2_reaccept_gap", qat(acc_e, 1), qat(done_e, 0) + 2);

    // Valid pulse while busy must not disturb the block in flight.
    clear_log();
    blk = 128'h0102030405060708090A0B0C0D0E0F10;
    send(blk);
    n = 0;
    while (strobe_bytes.size() < 4 && n < 200) begin step(1); n++; end
    block_i       = {16{8'hFF}};
    block_valid_i = 1'b1;
    step(1);
    block_valid_i = 1'b0;
    wait_done("t3");
    step(1);
    chk("t3_accepts", acc_e.size(), 1);
    chk("t3_strobes", strobe_bytes.size(), NB);
    check_block("t3", blk, 0);
    chk("t3_dones", done_e.size(), 1);

    // Stray ticks in IDLE and in START.
    clear_log();
    stray_tick = 1'b1;
    step(3);
    stray_tick = 1'b0;
    chk("t4_idle_strobes", strobe_bytes.size(), 0);
    chk("t4_idle_busy", {127'd0, busy_o}, 128'd0);
    blk = rand_blk();
    send(blk);
    stray_tick = 1'b1;
    step(1);
    stray_tick = 1'b0;
    wait_done("t4");
    step(1);
    chk("t4_strobes", strobe_bytes.size(), NB);
    check_block("t4", blk, 0);
    chk("t4_dones", done_e.size(), 1);

    // Reset in the WAIT of byte 5.
    clear_log();
    blk = rand_blk();
    send(blk);
    n = 0;
    while (strobe_bytes.size() < 6 && n < 400) begin step(1); n++; end
    step(5);
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_start", {127'd0, tx_start_o},    128'd0);
    chk("t5_rst_busy",  {127'd0, busy_o},        128'd0);
    chk("t5_rst_ready", {127'd0, block_ready_o}, 128'd1);
    chk("t5_rst_din",   {120'd0, tx_din_o},      128'd0);
    step(3);
    rst_ni = 1'b1;
    ns = strobe_bytes.size();
    step(60);
    chk("t5_no_strobes", strobe_bytes.size(), ns);
    chk("t5_no_done", done_e.size(), 0);
    chk("t5_ready_after", {127'd0, block_ready_o}, 128'd1);
    clear_log();
    blk = rand_blk();
    send(blk);
    wait_done("t5");
    step(1);
    chk("t5_strobes", strobe_bytes.size(), NB);
    check_block("t5", blk, 0);
    chk("t5_dones", done_e.size(), 1);

    // Random blocks with random transmitter speed and idle gaps.
    for (int r = 0; r < 4; r++) begin
      uart_delay = $urandom_range(2, 30);
      clear_log();
      step($urandom_range(0, 3));
      blk = rand_blk();
      send(blk);
      wait_done($sformatf("r%0d", r));
      step(1);
      chk($sformatf("r%0d_strobes", r), strobe_bytes.size(), NB);
      check_block($sformatf("r%0d", r), blk, 0);
      chk($sformatf("r%0d_dones", r), done_e.size(), 1);
      chk($sformatf("r%0d_din_stable", r), din_unstable, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
